// File: rtl/temp_voltage_pkg.sv
// Shared types and constants for the temperature/voltage acquisition path.
// The 64-bit word layout is also consumed by the downstream UDP sender.
package temp_voltage_pkg;

    localparam int unsigned WORD_W    = 64;
    localparam int unsigned FLAGS_W   = 8;
    localparam int unsigned SEQ_W     = 8;
    localparam int unsigned FIELD_W   = 24;
    localparam int unsigned OVF_W     = 16;

    localparam int unsigned FLAGS_MSB = 63;
    localparam int unsigned SEQ_MSB   = 55;
    localparam int unsigned TEMP_MSB  = 47;
    localparam int unsigned VOLT_MSB  = 23;

    localparam int unsigned FLAG_TEMP_TO = 0;
    localparam int unsigned FLAG_VOLT_TO = 1;
    localparam int unsigned FLAG_DROP    = 2;
    localparam int unsigned FLAG_MISSED  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [FLAGS_W-1:0] flags;
        logic [SEQ_W-1:0]   seq;
        logic [FIELD_W-1:0] temp;
        logic [FIELD_W-1:0] volt;
    } tv_word_t;

endpackage

// File: rtl/temp_voltage_sampler_if.sv
// Sensor request/valid handshakes and FIFO write port of the sampler.
interface temp_voltage_sampler_if
    import temp_voltage_pkg::*;
#(
    parameter int unsigned DATA_W = 24
);
    logic              temp_req;
    logic              temp_valid;
    logic [DATA_W-1:0] temp_data;
    logic              volt_req;
    logic              volt_valid;
    logic [DATA_W-1:0] volt_data;
    logic              fifo_clr;
    logic              fifo_wrreq;
    tv_word_t          fifo_wrdata;
    logic              fifo_wrfull;
    logic [OVF_W-1:0]  overflow_count;

    modport master (
        output temp_req, volt_req, fifo_wrreq, fifo_wrdata, overflow_count,
        input  temp_valid, temp_data, volt_valid, volt_data, fifo_clr, fifo_wrfull
    );

    modport slave (
        input  temp_req, volt_req, fifo_wrreq, fifo_wrdata, overflow_count,
        output temp_valid, temp_data, volt_valid, volt_data, fifo_clr, fifo_wrfull
    );
endinterface

// File: rtl/period_tick_gen.sv
// Enable-gated reloadable down-counter; emits a registered one-cycle tick
// every period_cycles clocks (a period of 0 behaves as 1).
module period_tick_gen #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_cycles,
    output logic             tick
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload_c;

    assign reload_c = (period_cycles == '0) ? '0 : period_cycles - 1'b1;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt_q <= reload_c;
            tick  <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q <= reload_c;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q - 1'b1;
            tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/temp_voltage_sampler.sv
// Periodic temperature/voltage acquisition: requests both sensors per tick,
// packs readings with seq/status flags and writes one word into the FIFO.
module temp_voltage_sampler
    import temp_voltage_pkg::*;
#(
    parameter int unsigned DATA_W         = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      period_cycles,
    temp_voltage_sampler_if.master bus
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic tick;

    period_tick_gen #(.CNT_W(CNT_W)) u_tick (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .period_cycles (period_cycles),
        .tick          (tick)
    );

    state_t            state_q, state_d;
    logic              temp_got_q, temp_got_d, volt_got_q, volt_got_d;
    logic [DATA_W-1:0] temp_q, temp_d, volt_q, volt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              drop_q, drop_d, missed_q, missed_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic              req_q, req_d, wrreq_q, wrreq_d;
    tv_word_t          wrdata_q, wrdata_d;

    logic              temp_have_c, volt_have_c, exit_c;
    logic [DATA_W-1:0] temp_sel_c, volt_sel_c;
    logic [FLAGS_W-1:0] flags_c;
    logic [WORD_W-1:0] word_c;

    // Word as it would be written this cycle, including same-cycle valids/tick
    always_comb begin
        temp_have_c = temp_got_q | bus.temp_valid;
        volt_have_c = volt_got_q | bus.volt_valid;
        temp_sel_c  = temp_got_q ? temp_q : (bus.temp_valid ? DATA_W'(bus.temp_data) : '0);
        volt_sel_c  = volt_got_q ? volt_q : (bus.volt_valid ? DATA_W'(bus.volt_data) : '0);
        flags_c                = '0;
        flags_c[FLAG_TEMP_TO]  = ~temp_have_c;
        flags_c[FLAG_VOLT_TO]  = ~volt_have_c;
        flags_c[FLAG_DROP]     = drop_q;
        flags_c[FLAG_MISSED]   = missed_q | tick;
        word_c                          = '0;
        word_c[FLAGS_MSB -: FLAGS_W]    = flags_c;
        word_c[SEQ_MSB   -: SEQ_W]      = seq_q;
        word_c[TEMP_MSB  -: FIELD_W]    = FIELD_W'(temp_sel_c);
        word_c[VOLT_MSB  -: FIELD_W]    = FIELD_W'(volt_sel_c);
        exit_c = (state_q == ST_WAIT) &&
                 ((temp_have_c && volt_have_c) || (tcnt_q == TO_W'(TIMEOUT_CYCLES)));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        temp_got_d = temp_got_q;
        volt_got_d = volt_got_q;
        temp_d     = temp_q;
        volt_d     = volt_q;
        tcnt_d     = tcnt_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        missed_d   = missed_q;
        ovf_d      = ovf_q;
        req_d      = 1'b0;
        wrreq_d    = 1'b0;
        wrdata_d   = wrdata_q;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d    = ST_WAIT;
                    req_d      = 1'b1;
                    temp_got_d = 1'b0;
                    volt_got_d = 1'b0;
                    temp_d     = '0;
                    volt_d     = '0;
                    tcnt_d     = '0;
                end
            end
            ST_WAIT: begin
                if (tick) missed_d = 1'b1;
                if (bus.temp_valid && !temp_got_q) begin
                    temp_got_d = 1'b1;
                    temp_d     = DATA_W'(bus.temp_data);
                end
                if (bus.volt_valid && !volt_got_q) begin
                    volt_got_d = 1'b1;
                    volt_d     = DATA_W'(bus.volt_data);
                end
                if (tcnt_q != TO_W'(TIMEOUT_CYCLES)) tcnt_d = tcnt_q + 1'b1;
                if (exit_c) begin
                    state_d = ST_IDLE;
                    if (!bus.fifo_wrfull) begin
                        wrreq_d  = 1'b1;
                        wrdata_d = word_c;
                        seq_d    = seq_q + 1'b1;
                        drop_d   = 1'b0;
                        missed_d = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                        if (ovf_q != '1) ovf_d = ovf_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Downstream clear wins over any acquisition activity this cycle
        if (bus.fifo_clr) begin
            state_d  = ST_IDLE;
            req_d    = 1'b0;
            wrreq_d  = 1'b0;
            wrdata_d = wrdata_q;
            seq_d    = '0;
            drop_d   = 1'b0;
            missed_d = 1'b0;
            ovf_d    = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            temp_got_q <= 1'b0;
            volt_got_q <= 1'b0;
            temp_q     <= '0;
            volt_q     <= '0;
            tcnt_q     <= '0;
            seq_q      <= '0;
            drop_q     <= 1'b0;
            missed_q   <= 1'b0;
            ovf_q      <= '0;
            req_q      <= 1'b0;
            wrreq_q    <= 1'b0;
            wrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            temp_got_q <= temp_got_d;
            volt_got_q <= volt_got_d;
            temp_q     <= temp_d;
            volt_q     <= volt_d;
            tcnt_q     <= tcnt_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            missed_q   <= missed_d;
            ovf_q      <= ovf_d;
            req_q      <= req_d;
            wrreq_q    <= wrreq_d;
            wrdata_q   <= wrdata_d;
        end
    end

    assign bus.temp_req       = req_q;
    assign bus.volt_req       = req_q;
    assign bus.fifo_wrreq     = wrreq_q;
    assign bus.fifo_wrdata    = wrdata_q;
    assign bus.overflow_count = ovf_q;
endmodule

// File: tb/tb_temp_voltage_sampler.sv
// Directed bench for temp_voltage_sampler: sensor responder, FIFO monitor,
// and one task per scenario with hand-computed expected words and timing.
module tb_temp_voltage_sampler;
    import temp_voltage_pkg::*;

    localparam int unsigned DATA_W  = 24;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [CNT_W-1:0] period_cycles;

    temp_voltage_sampler_if #(.DATA_W(DATA_W)) bus ();

    temp_voltage_sampler #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .period_cycles (period_cycles),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          temp_dly = -1;
    int          volt_dly = -1;
    logic [23:0] temp_val = '0;
    logic [23:0] volt_val = '0;
    logic [63:0] wq[$];
    int          wcyc[$];
    int          rq[$];
    int          nvreq = 0;
    int          cyc   = 0;

    // Sensor model: each valid fires a programmable number of cycles after req
    initial begin
        int tc, vc;
        tc = -1; vc = -1;
        bus.temp_valid = 1'b0; bus.volt_valid = 1'b0;
        bus.temp_data  = '0;   bus.volt_data  = '0;
        forever begin
            @(posedge clk); #1;
            bus.temp_valid = 1'b0;
            bus.volt_valid = 1'b0;
            if (bus.temp_req === 1'b1 && temp_dly >= 0) tc = temp_dly;
            if (bus.volt_req === 1'b1 && volt_dly >= 0) vc = volt_dly;
            if (tc == 0) begin bus.temp_valid = 1'b1; bus.temp_data = temp_val; end
            if (vc == 0) begin bus.volt_valid = 1'b1; bus.volt_data = volt_val; end
            if (tc >= 0) tc--;
            if (vc >= 0) vc--;
        end
    end

    // FIFO-side monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.fifo_wrreq === 1'b1) begin
                wq.push_back(bus.fifo_wrdata);
                wcyc.push_back(cyc);
            end
            if (bus.temp_req === 1'b1) rq.push_back(cyc);
            if (bus.volt_req === 1'b1) nvreq++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wq.delete(); wcyc.delete(); rq.delete(); nvreq = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0;
        bus.fifo_clr = 1'b0; bus.fifo_wrfull = 1'b0;
        step(12);
        reset = 1'b0;
        clear_logs();
        step(1);
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (wq.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        ok = (wq.size() >= n);
    endtask

    task automatic wait_reqs(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (rq.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        ok = (rq.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; period_cycles = 100;
        bus.fifo_clr = 1'b0; bus.fifo_wrfull = 1'b0;
        step(3);
        @(negedge clk);
        n_checks++; if (bus.temp_req !== 1'b0) begin n_fail++; $display("FAIL reset_temp_req: got %b required 0", bus.temp_req); end
        n_checks++; if (bus.volt_req !== 1'b0) begin n_fail++; $display("FAIL reset_volt_req: got %b required 0", bus.volt_req); end
        n_checks++; if (bus.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL reset_wrreq: got %b required 0", bus.fifo_wrreq); end
        n_checks++; if (bus.fifo_wrdata !== 64'h0) begin n_fail++; $display("FAIL reset_wrdata: got %h required 0", bus.fifo_wrdata); end
        n_checks++; if (bus.overflow_count !== 16'h0) begin n_fail++; $display("FAIL reset_overflow: got %h required 0", bus.overflow_count); end
        reset = 1'b0;
    endtask

    task automatic test_periodic();
        bit ok;
        do_reset();
        period_cycles = 100; temp_dly = 3; volt_dly = 3;
        temp_val = 24'h123456; volt_val = 24'h0ABCDE;
        enable = 1'b1;
        wait_words(3, 400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL periodic_wait: got %0d words required 3", wq.size()); return; end
        n_checks++; if (wq[0] !== 64'h00_00_123456_0ABCDE) begin n_fail++; $display("FAIL periodic_word0: got %h required %h", wq[0], 64'h00_00_123456_0ABCDE); end
        n_checks++; if (wq[1] !== 64'h00_01_123456_0ABCDE) begin n_fail++; $display("FAIL periodic_word1: got %h required %h", wq[1], 64'h00_01_123456_0ABCDE); end
        n_checks++; if (wq[2] !== 64'h00_02_123456_0ABCDE) begin n_fail++; $display("FAIL periodic_word2: got %h required %h", wq[2], 64'h00_02_123456_0ABCDE); end
        n_checks++; if (wcyc[1] - wcyc[0] !== 100) begin n_fail++; $display("FAIL periodic_spacing01: got %0d required 100", wcyc[1] - wcyc[0]); end
        n_checks++; if (wcyc[2] - wcyc[1] !== 100) begin n_fail++; $display("FAIL periodic_spacing12: got %0d required 100", wcyc[2] - wcyc[1]); end
        n_checks++; if (wcyc[0] - rq[0] !== 4) begin n_fail++; $display("FAIL periodic_latency: got %0d required 4", wcyc[0] - rq[0]); end
        enable = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        period_cycles = 100; temp_dly = 1; volt_dly = -1;
        temp_val = 24'h00BEEF; volt_val = 24'h777777;
        enable = 1'b1;
        wait_words(1, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL timeout_wait: got %0d words required 1", wq.size()); return; end
        n_checks++; if (wq[0] !== 64'h02_00_00BEEF_000000) begin n_fail++; $display("FAIL timeout_word: got %h required %h", wq[0], 64'h02_00_00BEEF_000000); end
        n_checks++; if (wcyc[0] - rq[0] !== 17) begin n_fail++; $display("FAIL timeout_latency: got %0d required 17", wcyc[0] - rq[0]); end
        enable = 1'b0;
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        period_cycles = 40; temp_dly = 2; volt_dly = 2;
        temp_val = 24'h111111; volt_val = 24'h222222;
        enable = 1'b1;
        wait_words(2, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL full_prefill: got %0d words required 2", wq.size()); return; end
        bus.fifo_wrfull = 1'b1;
        wait_reqs(5, 200, ok);
        step(10);
        bus.fifo_wrfull = 1'b0;
        n_checks++; if (wq.size() !== 2) begin n_fail++; $display("FAIL full_no_write: got %0d words required 2", wq.size()); end
        n_checks++; if (bus.overflow_count !== 16'd3) begin n_fail++; $display("FAIL full_overflow: got %0d required 3", bus.overflow_count); end
        wait_words(4, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL full_resume: got %0d words required 4", wq.size()); return; end
        n_checks++; if (wq[2] !== 64'h04_02_111111_222222) begin n_fail++; $display("FAIL full_drop_word: got %h required %h", wq[2], 64'h04_02_111111_222222); end
        n_checks++; if (wq[3] !== 64'h00_03_111111_222222) begin n_fail++; $display("FAIL full_after_word: got %h required %h", wq[3], 64'h00_03_111111_222222); end
        enable = 1'b0;
    endtask

    task automatic test_missed();
        bit ok;
        logic [63:0] exp;
        do_reset();
        period_cycles = 4; temp_dly = 10; volt_dly = 10;
        temp_val = 24'hA5A5A5; volt_val = 24'h5A5A5A;
        enable = 1'b1;
        wait_words(3, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL missed_wait: got %0d words required 3", wq.size()); return; end
        for (int k = 0; k < 3; k++) begin
            exp = {8'h08, 8'(k), 24'hA5A5A5, 24'h5A5A5A};
            n_checks++; if (wq[k] !== exp) begin n_fail++; $display("FAIL missed_word%0d: got %h required %h", k, wq[k], exp); end
        end
        n_checks++; if (rq.size() !== 3) begin n_fail++; $display("FAIL missed_temp_reqs: got %0d required 3", rq.size()); end
        n_checks++; if (nvreq !== 3) begin n_fail++; $display("FAIL missed_volt_reqs: got %0d required 3", nvreq); end
        n_checks++; if (rq[1] - rq[0] !== 12) begin n_fail++; $display("FAIL missed_req_spacing: got %0d required 12", rq[1] - rq[0]); end
        enable = 1'b0;
    endtask

    task automatic test_clear();
        bit ok;
        do_reset();
        period_cycles = 50; temp_dly = 8; volt_dly = 8;
        temp_val = 24'h0F0F0F; volt_val = 24'h00FF00;
        enable = 1'b1;
        wait_words(2, 200, ok);
        if (ok) wait_reqs(3, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL clear_setup: got %0d words required 2", wq.size()); return; end
        step(3);
        bus.fifo_clr = 1'b1;
        step(1);
        bus.fifo_clr = 1'b0;
        step(15);
        n_checks++; if (wq.size() !== 2) begin n_fail++; $display("FAIL clear_no_write: got %0d words required 2", wq.size()); end
        wait_words(3, 100, ok);
        n_checks++;
        if (!ok || rq.size() < 4) begin n_fail++; $display("FAIL clear_resume: got %0d words required 3", wq.size()); return; end
        n_checks++; if (wq[2] !== 64'h00_00_0F0F0F_00FF00) begin n_fail++; $display("FAIL clear_word: got %h required %h", wq[2], 64'h00_00_0F0F0F_00FF00); end
        n_checks++; if (rq[3] - rq[2] !== 50) begin n_fail++; $display("FAIL clear_tick_phase: got %0d required 50", rq[3] - rq[2]); end
        enable = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        bit ok;
        logic [63:0] w;
        int nw;
        do_reset();
        period_cycles = 8; temp_dly = 0; volt_dly = 0;
        temp_val = 24'h000001; volt_val = 24'h000002;
        enable = 1'b1;
        wait_words(260, 260 * 8 + 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_wait: got %0d words required 260", wq.size()); return; end
        w = wq[255];
        n_checks++; if (w[55:48] !== 8'hFF) begin n_fail++; $display("FAIL wrap_seq255: got %h required ff", w[55:48]); end
        w = wq[256];
        n_checks++; if (w[55:48] !== 8'h00) begin n_fail++; $display("FAIL wrap_seq256: got %h required 00", w[55:48]); end
        n_checks++; if (wq[259] !== 64'h00_03_000001_000002) begin n_fail++; $display("FAIL wrap_word259: got %h required %h", wq[259], 64'h00_03_000001_000002); end
        n_checks++; if (wcyc[256] - wcyc[255] !== 8) begin n_fail++; $display("FAIL wrap_spacing: got %0d required 8", wcyc[256] - wcyc[255]); end
        temp_dly = 5; volt_dly = 5;
        wait_reqs(rq.size() + 1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midwait_req: no req within 20 cycles"); return; end
        step(2);
        reset = 1'b1; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.temp_req !== 1'b0) begin n_fail++; $display("FAIL midwait_temp_req: got %b required 0", bus.temp_req); end
        n_checks++; if (bus.volt_req !== 1'b0) begin n_fail++; $display("FAIL midwait_volt_req: got %b required 0", bus.volt_req); end
        n_checks++; if (bus.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL midwait_wrreq: got %b required 0", bus.fifo_wrreq); end
        n_checks++; if (bus.fifo_wrdata !== 64'h0) begin n_fail++; $display("FAIL midwait_wrdata: got %h required 0", bus.fifo_wrdata); end
        n_checks++; if (bus.overflow_count !== 16'h0) begin n_fail++; $display("FAIL midwait_overflow: got %h required 0", bus.overflow_count); end
        nw = wq.size();
        step(3);
        reset = 1'b0;
        step(20);
        n_checks++; if (wq.size() !== nw) begin n_fail++; $display("FAIL midwait_stray_write: got %0d words required %0d", wq.size(), nw); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; period_cycles = 100;
        bus.fifo_clr = 1'b0; bus.fifo_wrfull = 1'b0;
        test_reset();
        test_periodic();
        test_timeout();
        test_full();
        test_missed();
        test_clear();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
